// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: per-channel state encoding and
// the counter-width helper used to size the ON/GAP down-counter.
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Wide enough to hold the larger of the two load values without wrapping.
   function automatic int cnt_width(input int on_cycles, input int gap_cycles);
      int m;
      m = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// Single stretcher channel: IDLE/ON/GAP FSM with a shared down-counter and a
// one-deep pending slot for events that arrive while the channel is busy.
module pulse_stretcher_channel
   import pulse_stretcher_pkg::*;
#(
   parameter int ON_CYCLES  = 25_000_000,
   parameter int GAP_CYCLES = 5_000_000,
   parameter int RETRIGGER  = 1,
   parameter int CNT_W      = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse_i,
   output logic stretch_o,
   output logic busy_o,
   output logic overrun_o
);

   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             stretch_q, stretch_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             take;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         stretch_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         stretch_q <= stretch_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   // A pulse landing on the expiry cycle counts as pending, so it is consumed
   // immediately rather than being lost or delayed by a dark cycle.
   assign take = pending_q | pulse_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      overrun_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pulse_i) begin
               state_d = ST_ON;
               cnt_d   = ON_LOAD;
            end
         end
         ST_ON: begin
            if (pulse_i && (RETRIGGER != 0)) begin
               cnt_d = ON_LOAD;
            end else if (cnt_q == '0) begin
               if (GAP_CYCLES != 0) begin
                  state_d   = ST_GAP;
                  cnt_d     = GAP_LOAD;
                  pending_d = pending_q | pulse_i;
                  overrun_d = pending_q & pulse_i;
               end else if (take) begin
                  cnt_d     = ON_LOAD;
                  pending_d = pending_q & pulse_i;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (pulse_i) begin
                  pending_d = 1'b1;
                  overrun_d = pending_q;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               if (take) begin
                  state_d   = ST_ON;
                  cnt_d     = ON_LOAD;
                  pending_d = pending_q & pulse_i;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (pulse_i) begin
                  pending_d = 1'b1;
                  overrun_d = pending_q;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      stretch_d = (state_d == ST_ON);
      busy_d    = (state_d != ST_IDLE);
   end

   assign stretch_o = stretch_q;
   assign busy_o    = busy_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: turns single-cycle events into fixed-length
// LED-visible flashes with an enforced dark gap; channels are independent.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int CH         = 4,
   parameter int ON_CYCLES  = 25_000_000,
   parameter int GAP_CYCLES = 5_000_000,
   parameter int RETRIGGER  = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] pulse_in,
   output logic [CH-1:0] stretch_out,
   output logic [CH-1:0] busy,
   output logic [CH-1:0] overrun
);

   localparam int CNT_W = cnt_width(ON_CYCLES, GAP_CYCLES);

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         pulse_stretcher_channel #(
            .ON_CYCLES  (ON_CYCLES),
            .GAP_CYCLES (GAP_CYCLES),
            .RETRIGGER  (RETRIGGER),
            .CNT_W      (CNT_W)
         ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .pulse_i   (pulse_in[gi]),
            .stretch_o (stretch_out[gi]),
            .busy_o    (busy[gi]),
            .overrun_o (overrun[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: three pulse_stretcher configurations driven in parallel with
// hand-computed per-cycle expectations for flash, retrigger, queue and overrun.
module tb_pulse_stretcher;

   logic       clk;
   logic       reset;
   logic [3:0] pulse_a, pulse_b, pulse_c;
   logic [3:0] st_a, busy_a, ov_a;
   logic [3:0] st_b, busy_b, ov_b;
   logic [3:0] st_c, busy_c, ov_c;

   int n_vec;
   int n_err;

   // a: retrigger, gap 2; b: queued, gap 2; c: queued, no gap
   pulse_stretcher #(.CH(4), .ON_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1)) dut_a (
      .clk(clk), .reset(reset), .pulse_in(pulse_a),
      .stretch_out(st_a), .busy(busy_a), .overrun(ov_a));
   pulse_stretcher #(.CH(4), .ON_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)) dut_b (
      .clk(clk), .reset(reset), .pulse_in(pulse_b),
      .stretch_out(st_b), .busy(busy_b), .overrun(ov_b));
   pulse_stretcher #(.CH(4), .ON_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(0)) dut_c (
      .clk(clk), .reset(reset), .pulse_in(pulse_c),
      .stretch_out(st_c), .busy(busy_c), .overrun(ov_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic win(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_st_a"}, st_a, 4'b0);
      chk({tag, "_busy_a"}, busy_a, 4'b0);
      chk({tag, "_ov_a"}, ov_a, 4'b0);
      chk({tag, "_st_b"}, st_b, 4'b0);
      chk({tag, "_busy_b"}, busy_b, 4'b0);
      chk({tag, "_ov_b"}, ov_b, 4'b0);
      chk({tag, "_st_c"}, st_c, 4'b0);
      chk({tag, "_busy_c"}, busy_c, 4'b0);
      chk({tag, "_ov_c"}, ov_c, 4'b0);
   endtask

   initial begin
      logic [3:0] e_st, e_busy, e_ov;
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      pulse_a = '0;
      pulse_b = '0;
      pulse_c = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // Phase 1: single flash, retrigger, queued event, overrun, no-gap chaining.
      for (int c = 0; c <= 24; c++) begin
         @(negedge clk);
         e_st   = {2'b00, win(c, 11, 16), win(c, 11, 14)};
         e_busy = {2'b00, win(c, 11, 18), win(c, 11, 16)};
         chk($sformatf("a_stretch@%0d", c), st_a, e_st);
         chk($sformatf("a_busy@%0d", c), busy_a, e_busy);
         chk($sformatf("a_overrun@%0d", c), ov_a, 4'b0);

         e_st   = {win(c, 11, 14) | win(c, 17, 20), win(c, 11, 14) | win(c, 17, 20), 2'b00};
         e_busy = {win(c, 11, 22), win(c, 11, 22), 2'b00};
         e_ov   = {(c == 13), 3'b000};
         chk($sformatf("b_stretch@%0d", c), st_b, e_st);
         chk($sformatf("b_busy@%0d", c), busy_b, e_busy);
         chk($sformatf("b_overrun@%0d", c), ov_b, e_ov);

         e_st = {3'b000, win(c, 11, 18)};
         chk($sformatf("c_stretch@%0d", c), st_c, e_st);
         chk($sformatf("c_busy@%0d", c), busy_c, e_st);
         chk($sformatf("c_overrun@%0d", c), ov_c, 4'b0);

         pulse_a = '0;
         pulse_b = '0;
         pulse_c = '0;
         if (c == 10) begin
            pulse_a = 4'b0011;
            pulse_b = 4'b1100;
            pulse_c = 4'b0001;
         end
         if (c == 11) pulse_b = 4'b1000;
         if (c == 12) begin
            pulse_a = 4'b0010;
            pulse_b = 4'b1100;
         end
         if (c == 14) pulse_c = 4'b0001;
      end

      // Phase 2: reset mid-flash truncates it and wins over same-cycle pulses.
      reset   = 1'b1;
      pulse_a = '0;
      pulse_b = '0;
      pulse_c = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         e_st = {3'b000, win(c, 11, 12)};
         chk($sformatf("rst_a_stretch@%0d", c), st_a, e_st);
         chk($sformatf("rst_a_busy@%0d", c), busy_a, e_st);
         chk($sformatf("rst_a_overrun@%0d", c), ov_a, 4'b0);
         chk($sformatf("rst_b_stretch@%0d", c), st_b, 4'b0);
         chk($sformatf("rst_b_busy@%0d", c), busy_b, 4'b0);

         reset   = (c == 12);
         pulse_a = '0;
         pulse_b = '0;
         if (c == 10) pulse_a = 4'b0001;
         if (c == 12) begin
            pulse_a = 4'b0011;
            pulse_b = 4'b1111;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
